// File: rtl/adc_serial_reader_pkg.sv
// Shared types and defaults for the serial ADC reader.
package adc_serial_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } state_t;

  localparam int FRAME_BITS_DEF = 16;
  localparam int DATA_BITS_DEF  = 12;

  typedef logic [DATA_BITS_DEF-1:0] sample_t;

endpackage

// File: rtl/adc_serial_reader_sclk_tick_gen.sv
// Half-period counter: counts 0..limit, pulses tc on the terminal count and
// wraps to 0. Held at 0 while clr is high.
module sclk_tick_gen #(
  parameter int CNT_W = 6
) (
  input  logic             Clck_in,
  input  logic             reset_Clock,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == limit);

  // Free-running count with synchronous clear and wrap at the terminal count.
  always_ff @(posedge Clck_in) begin
    if (reset_Clock || clr) cnt <= '0;
    else if (tc)            cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/adc_serial_reader.sv
// Reader for an AD7476-style serial ADC: one request -> one 16-bit frame,
// the low DATA_BITS bits are delivered with a one-cycle valid strobe.
module adc_serial_reader
  import adc_serial_reader_pkg::*;
#(
  parameter int HALF_PERIOD = 25,
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int DATA_BITS   = DATA_BITS_DEF
) (
  input  logic                 Clck_in,
  input  logic                 reset_Clock,
  input  logic                 start,
  input  logic                 sdata,
  output logic                 cs_n,
  output logic                 sclk,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 busy
);

  localparam int CW = $clog2(2*HALF_PERIOD+1);
  localparam int BW = $clog2(FRAME_BITS+1);

  state_t               state, state_d;
  logic                 req, req_d;
  logic                 cs_n_d, sclk_d, busy_d, dv_d;
  logic [DATA_BITS-1:0] data_d;
  // Only the bits that can still land in the sample are kept; the newest
  // bit comes straight from sdata when the frame closes.
  logic [DATA_BITS-2:0] sreg, sreg_d;
  logic [BW-1:0]        bcnt, bcnt_d;
  logic                 tc;
  logic [CW-1:0]        limit;

  // QUIET spans a full sclk period, SETUP and SHIFT one half-period.
  assign limit = (state == QUIET) ? CW'(2*HALF_PERIOD-1) : CW'(HALF_PERIOD-1);

  sclk_tick_gen #(.CNT_W(CW)) u_tick (
    .Clck_in     (Clck_in),
    .reset_Clock (reset_Clock),
    .clr         (state == IDLE),
    .limit       (limit),
    .tc          (tc)
  );

  // Next-state and next-output logic; outputs are all registered below.
  always_comb begin
    state_d = state;
    req_d   = req;
    cs_n_d  = cs_n;
    sclk_d  = sclk;
    busy_d  = busy;
    dv_d    = 1'b0;
    data_d  = data;
    sreg_d  = sreg;
    bcnt_d  = bcnt;
    case (state)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        busy_d = 1'b0;
        // Request is latched one cycle, then the frame opens.
        if (req) begin
          req_d   = 1'b0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end else if (start) begin
          req_d = 1'b1;
        end
      end
      SETUP: begin
        if (tc) begin
          sclk_d  = 1'b0;
          bcnt_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tc) begin
          sclk_d = ~sclk;
          if (!sclk) begin
            // Rising sclk: capture the bit the ADC is presenting.
            sreg_d = {sreg[DATA_BITS-3:0], sdata};
            bcnt_d = bcnt + 1'b1;
            if (bcnt == BW'(FRAME_BITS-1)) begin
              data_d  = {sreg, sdata};
              dv_d    = 1'b1;
              cs_n_d  = 1'b1;
              state_d = QUIET;
            end
          end
        end
      end
      QUIET: begin
        if (tc) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clck_in) begin
    if (reset_Clock) begin
      state      <= IDLE;
      req        <= 1'b0;
      cs_n       <= 1'b1;
      sclk       <= 1'b1;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data       <= '0;
      sreg       <= '0;
      bcnt       <= '0;
    end else begin
      state      <= state_d;
      req        <= req_d;
      cs_n       <= cs_n_d;
      sclk       <= sclk_d;
      busy       <= busy_d;
      data_valid <= dv_d;
      data       <= data_d;
      sreg       <= sreg_d;
      bcnt       <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Directed bench for adc_serial_reader: HALF_PERIOD=2 main instance plus a
// HALF_PERIOD=1 instance for the fastest-sclk case.
module tb_adc_serial_reader;
  import adc_serial_reader_pkg::*;

  localparam int HP = 2;

  logic    clk = 1'b0, rst = 1'b1;
  logic    start = 1'b0, start1 = 1'b0;
  logic    sdata, sdata1;
  logic    cs_n, sclk, busy, dv;
  logic    cs_n1, sclk1, busy1, dv1;
  sample_t data, data1;

  int n_chk = 0, n_fail = 0;

  adc_serial_reader #(.HALF_PERIOD(HP)) dut (
    .Clck_in(clk), .reset_Clock(rst), .start(start), .sdata(sdata),
    .cs_n(cs_n), .sclk(sclk), .data(data), .data_valid(dv), .busy(busy));

  adc_serial_reader #(.HALF_PERIOD(1)) dut1 (
    .Clck_in(clk), .reset_Clock(rst), .start(start1), .sdata(sdata1),
    .cs_n(cs_n1), .sclk(sclk1), .data(data1), .data_valid(dv1), .busy(busy1));

  always #5 clk = ~clk;

  // ADC models: MSB first at cs_n fall, next bit after each sclk rise.
  logic [15:0] frame = '0, frame1 = '0;
  int          bidx = 16, bidx1 = 16;
  logic        noise = 1'b0;
  always @(negedge clk) noise <= ~noise;
  always @(negedge cs_n)  bidx = 0;
  always @(posedge sclk)  if (bidx < 16) bidx++;
  always @(negedge cs_n1) bidx1 = 0;
  always @(posedge sclk1) if (bidx1 < 16) bidx1++;
  assign sdata  = (bidx  < 16) ? frame[4'(15-bidx)]   : noise;
  assign sdata1 = (bidx1 < 16) ? frame1[4'(15-bidx1)] : noise;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One start pulse at edge 0, then observe the whole frame.
  task automatic run_frame(input logic [15:0] f, input sample_t exp, input string tag);
    int cs_fall = -1, sclk_fall = -1, dv_edge = -1, busy_fall = -1;
    int dv_cnt = 0, rises = 0;
    logic ps, cs_at_dv;
    sample_t dgot;
    cs_at_dv = 1'b0;
    dgot = '0;
    frame = f;
    start = 1'b1;
    step();
    start = 1'b0;
    ps = sclk;
    for (int e = 1; e <= 90; e++) begin
      step();
      if (cs_fall < 0 && !cs_n) cs_fall = e;
      if (sclk_fall < 0 && !sclk) sclk_fall = e;
      if (!ps && sclk) rises++;
      ps = sclk;
      if (dv) begin
        dv_cnt++;
        if (dv_edge < 0) begin dv_edge = e; dgot = data; cs_at_dv = cs_n; end
      end
      if (busy_fall < 0 && e > 1 && !busy) busy_fall = e;
    end
    chk({tag, ".cs_fall"},   cs_fall,   1);
    chk({tag, ".sclk_fall"}, sclk_fall, 1 + HP);
    chk({tag, ".rises"},     rises,     16);
    chk({tag, ".dv_edge"},   dv_edge,   1 + 32*HP);
    chk({tag, ".dv_cnt"},    dv_cnt,    1);
    chk({tag, ".data"},      dgot,      exp);
    chk({tag, ".cs_at_dv"},  cs_at_dv,  1);
    chk({tag, ".busy_fall"}, busy_fall, 1 + 34*HP);
    chk({tag, ".data_hold"}, data,      exp);
  endtask

  typedef struct {
    logic [15:0] f;
    sample_t     d;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h0A5C, 12'hA5C};
    tbl[1] = '{16'hFFFF, 12'hFFF};
    tbl[2] = '{16'h0000, 12'h000};
    tbl[3] = '{16'h8001, 12'h001};
    tbl[4] = '{16'hF800, 12'h800};
    tbl[5] = '{16'h5A5A, 12'hA5A};

    // Reset state, then 100 idle cycles with sdata toggling.
    repeat (3) step();
    chk("reset.outs", {cs_n, sclk, busy, dv, data}, {1'b1, 1'b1, 1'b0, 1'b0, 12'h000});
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("idle.outs", {cs_n, sclk, busy, dv, data}, {1'b1, 1'b1, 1'b0, 1'b0, 12'h000});
    end

    // Table of single frames.
    for (int i = 0; i < 6; i++) run_frame(tbl[i].f, tbl[i].d, $sformatf("vec%0d", i));

    // start held high: back-to-back frames every 70 cycles.
    begin
      int dv_e[$];
      int hi_cnt = 0, sclk_bad = 0;
      bit counting = 0, done = 0;
      frame = 16'h0A5C;
      start = 1'b1;
      for (int e = 0; e < 230; e++) begin
        step();
        if (cs_n && sclk !== 1'b1) sclk_bad++;
        if (counting && !done) begin
          if (cs_n) hi_cnt++;
          else done = 1;
        end
        if (dv) begin
          dv_e.push_back(e);
          counting = 1;
        end
      end
      start = 1'b0;
      chk("b2b.dv_cnt", dv_e.size(), 3);
      if (dv_e.size() == 3) begin
        chk("b2b.first",   dv_e[0], 65);
        chk("b2b.period1", dv_e[1] - dv_e[0], 70);
        chk("b2b.period2", dv_e[2] - dv_e[1], 70);
      end
      chk("b2b.cs_high", hi_cnt, 5);
      chk("b2b.sclk_idle", sclk_bad, 0);
      repeat (80) step();
    end

    // Reset after the 8th sclk rise discards the frame and clears data.
    begin
      int rises = 0, dvs = 0;
      logic ps;
      frame = 16'h0A5C;
      start = 1'b1;
      step();
      start = 1'b0;
      ps = sclk;
      for (int e = 1; e <= 40 && rises < 8; e++) begin
        step();
        if (!ps && sclk) rises++;
        ps = sclk;
      end
      chk("rst_mid.rises", rises, 8);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid.outs", {cs_n, sclk, busy, dv, data}, {1'b1, 1'b1, 1'b0, 1'b0, 12'h000});
      for (int e = 0; e < 80; e++) begin
        step();
        if (dv || !cs_n) dvs++;
      end
      chk("rst_mid.quiet", dvs, 0);
      run_frame(16'h0123, 12'h123, "post_rst");
    end

    // start pulses during SHIFT and QUIET are ignored.
    begin
      int dvs = 0;
      frame = 16'h0C3A;
      start = 1'b1;
      step();
      for (int e = 1; e <= 150; e++) begin
        start = (e == 20 || e == 66);
        step();
        if (dv) dvs++;
      end
      start = 1'b0;
      chk("ignore.dv_cnt", dvs, 1);
      chk("ignore.data", data, 12'hC3A);
      chk("ignore.idle", {cs_n, busy}, {1'b1, 1'b0});
    end

    // HALF_PERIOD=1: sclk toggles every cycle, valid at edge 33.
    begin
      int dv_edge = -1, dvs = 0;
      sample_t dgot = '0;
      frame1 = 16'h0FFF;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      for (int e = 1; e <= 50; e++) begin
        step();
        if (dv1) begin
          dvs++;
          if (dv_edge < 0) begin dv_edge = e; dgot = data1; end
        end
      end
      chk("hp1.dv_edge", dv_edge, 33);
      chk("hp1.dv_cnt", dvs, 1);
      chk("hp1.data", dgot, 12'hFFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
